// File: rtl/ov7670_pixel_capture.sv
// OV7670 capture back end: pairs RGB565 bytes into RGB332 pixels, crops to WIDTH x HEIGHT, writes the frame buffer.
// Define OV7670_TEST_PATTERN_EN to replace camera data with an x^y test pattern.
module ov7670_pixel_capture #(
  parameter int WIDTH  = 176,
  parameter int HEIGHT = 144,
  parameter int ADDR_W = 15
) (
  input  logic              PCLK,
  input  logic              reset,
  input  logic              VSYNC,
  input  logic              HREF,
  input  logic [7:0]        PIXEL_DATA,
  output logic [ADDR_W-1:0] WRITE_ADDR,
  output logic [7:0]        WRITE_DATA,
  output logic              WRITE_EN,
  output logic              FRAME_DONE
);

  localparam int XW = $clog2(WIDTH + 1);
  localparam int YW = $clog2(HEIGHT + 1);
  localparam int BW = ADDR_W + 1;

  localparam logic [XW-1:0] X_MAX     = XW'(WIDTH);
  localparam logic [YW-1:0] Y_MAX     = YW'(HEIGHT);
  localparam logic [BW-1:0] LINE_STEP = BW'(WIDTH);

  localparam logic [1:0] S_WAIT_VS_HIGH = 2'd0;
  localparam logic [1:0] S_WAIT_VS_LOW  = 2'd1;
  localparam logic [1:0] S_CAPTURE      = 2'd2;

  localparam logic PHASE_HI = 1'b0;
  localparam logic PHASE_LO = 1'b1;

`ifdef OV7670_TEST_PATTERN_EN
  function automatic logic [7:0] test_pattern(input logic [XW-1:0] x, input logic [YW-1:0] y);
    return 8'(x) ^ 8'(y);
  endfunction
`else
  function automatic logic [7:0] rgb332(input logic [5:0] rg, input logic [1:0] b);
    return {rg, b};
  endfunction
`endif

  logic [1:0]        state_q, state_d;
  logic              vsync_q, vsync_d;
  logic              href_q, href_d;
  logic              phase_q, phase_d;
  logic [XW-1:0]     x_q, x_d;
  logic [YW-1:0]     y_q, y_d;
  logic [BW-1:0]     base_q, base_d;
  logic              wr_en_q, wr_en_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [7:0]        wr_data_q, wr_data_d;
  logic              frame_done_q, frame_done_d;
`ifndef OV7670_TEST_PATTERN_EN
  // Only the R3 and G3 source bits of the high byte are ever needed.
  logic [5:0]        hi_q, hi_d;
`endif

  logic vs_rise, vs_fall, href_fall, in_window;

  assign vs_rise   = VSYNC & ~vsync_q;
  assign vs_fall   = ~VSYNC & vsync_q;
  assign href_fall = ~HREF & href_q;
  assign in_window = (x_q < X_MAX) && (y_q < Y_MAX);

  always_comb begin
    state_d      = state_q;
    vsync_d      = VSYNC;
    href_d       = HREF;
    phase_d      = phase_q;
    x_d          = x_q;
    y_d          = y_q;
    base_d       = base_q;
    wr_en_d      = 1'b0;
    wr_addr_d    = wr_addr_q;
    wr_data_d    = wr_data_q;
    frame_done_d = 1'b0;
`ifndef OV7670_TEST_PATTERN_EN
    hi_d         = hi_q;
`endif

    case (state_q)
      S_WAIT_VS_HIGH: begin
        if (VSYNC) begin
          state_d = S_WAIT_VS_LOW;
        end
      end

      S_WAIT_VS_LOW: begin
        if (vs_fall) begin
          state_d = S_CAPTURE;
          x_d     = '0;
          y_d     = '0;
          base_d  = '0;
          phase_d = PHASE_HI;
        end
      end

      S_CAPTURE: begin
        if (vs_rise) begin
          // End of frame wins over any byte on the bus; a half pixel is dropped.
          state_d      = S_WAIT_VS_LOW;
          frame_done_d = 1'b1;
          phase_d      = PHASE_HI;
        end else if (HREF) begin
          if (phase_q == PHASE_HI) begin
`ifndef OV7670_TEST_PATTERN_EN
            hi_d    = {PIXEL_DATA[7:5], PIXEL_DATA[2:0]};
`endif
            phase_d = PHASE_LO;
          end else begin
            phase_d = PHASE_HI;
            if (in_window) begin
              wr_en_d   = 1'b1;
              wr_addr_d = ADDR_W'(base_q + BW'(x_q));
`ifdef OV7670_TEST_PATTERN_EN
              wr_data_d = test_pattern(x_q, y_q);
`else
              wr_data_d = rgb332(hi_q, PIXEL_DATA[4:3]);
`endif
            end
            if (x_q != X_MAX) begin
              x_d = x_q + 1'b1;
            end
          end
        end else if (href_fall) begin
          // A line only counts if it delivered a full pixel; base tracks y*WIDTH without a multiplier.
          phase_d = PHASE_HI;
          if (x_q != '0) begin
            x_d = '0;
            if (y_q != Y_MAX) begin
              y_d    = y_q + 1'b1;
              base_d = base_q + LINE_STEP;
            end
          end
        end
      end

      default: state_d = S_WAIT_VS_HIGH;
    endcase
  end

  always_ff @(posedge PCLK) begin
    if (reset) begin
      state_q      <= S_WAIT_VS_HIGH;
      vsync_q      <= 1'b0;
      href_q       <= 1'b0;
      phase_q      <= PHASE_HI;
      x_q          <= '0;
      y_q          <= '0;
      base_q       <= '0;
      wr_en_q      <= 1'b0;
      wr_addr_q    <= '0;
      wr_data_q    <= 8'h00;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      vsync_q      <= vsync_d;
      href_q       <= href_d;
      phase_q      <= phase_d;
      x_q          <= x_d;
      y_q          <= y_d;
      base_q       <= base_d;
      wr_en_q      <= wr_en_d;
      wr_addr_q    <= wr_addr_d;
      wr_data_q    <= wr_data_d;
      frame_done_q <= frame_done_d;
    end
  end

`ifndef OV7670_TEST_PATTERN_EN
  always_ff @(posedge PCLK) begin
    hi_q <= hi_d;
  end
`endif

  assign WRITE_ADDR = wr_addr_q;
  assign WRITE_DATA = wr_data_q;
  assign WRITE_EN   = wr_en_q;
  assign FRAME_DONE = frame_done_q;

endmodule

// File: tb/tb_ov7670_pixel_capture.sv
// Directed bench for ov7670_pixel_capture at WIDTH=4, HEIGHT=2; expected data follows OV7670_TEST_PATTERN_EN.
module tb_ov7670_pixel_capture;

  localparam int W  = 4;
  localparam int H  = 2;
  localparam int AW = 15;

  logic          PCLK       = 1'b0;
  logic          reset      = 1'b1;
  logic          VSYNC      = 1'b0;
  logic          HREF       = 1'b0;
  logic [7:0]    PIXEL_DATA = 8'h00;
  logic [AW-1:0] WRITE_ADDR;
  logic [7:0]    WRITE_DATA;
  logic          WRITE_EN;
  logic          FRAME_DONE;

  int vectors     = 0;
  int miscompares = 0;
  int writes      = 0;

  logic [7:0] hi_t  [4] = '{8'hF8, 8'h07, 8'h00, 8'hFF};
  logic [7:0] lo_t  [4] = '{8'h00, 8'hE0, 8'h1F, 8'hFF};
  logic [7:0] rgb_t [4] = '{8'hE0, 8'h1C, 8'h03, 8'hFF};

  ov7670_pixel_capture #(.WIDTH(W), .HEIGHT(H), .ADDR_W(AW)) dut (
    .PCLK       (PCLK),
    .reset      (reset),
    .VSYNC      (VSYNC),
    .HREF       (HREF),
    .PIXEL_DATA (PIXEL_DATA),
    .WRITE_ADDR (WRITE_ADDR),
    .WRITE_DATA (WRITE_DATA),
    .WRITE_EN   (WRITE_EN),
    .FRAME_DONE (FRAME_DONE)
  );

  always #5 PCLK = ~PCLK;

  function automatic logic [7:0] exp_data(input int x, input int y);
`ifdef OV7670_TEST_PATTERN_EN
    return 8'(x ^ y);
`else
    return rgb_t[x % 4];
`endif
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One PCLK: drive on the falling edge, sample 1 ns after the rising edge.
  task automatic cyc(input logic vs, input logic hr, input logic [7:0] d,
                     input logic en, input int ad, input logic [7:0] dt, input logic fd);
    @(negedge PCLK);
    VSYNC      = vs;
    HREF       = hr;
    PIXEL_DATA = d;
    @(posedge PCLK);
    #1;
    check("write_en", WRITE_EN, en);
    check("frame_done", FRAME_DONE, fd);
    if (WRITE_EN) writes++;
    if (en) begin
      check("write_addr", WRITE_ADDR, ad);
      check("write_data", WRITE_DATA, dt);
    end
  endtask

  task automatic pixels(input int first, input int n, input int yy, input bit live);
    for (int i = first; i < first + n; i++) begin
      cyc(1'b0, 1'b1, hi_t[i % 4], 1'b0, 0, 8'h00, 1'b0);
      cyc(1'b0, 1'b1, lo_t[i % 4], live && (i < W) && (yy < H), yy * W + i, exp_data(i, yy), 1'b0);
    end
  endtask

  task automatic href_low();
    cyc(1'b0, 1'b0, 8'h00, 1'b0, 0, 8'h00, 1'b0);
  endtask

  task automatic start_frame();
    cyc(1'b1, 1'b0, 8'h00, 1'b0, 0, 8'h00, 1'b0);
    cyc(1'b1, 1'b0, 8'h00, 1'b0, 0, 8'h00, 1'b0);
    cyc(1'b0, 1'b0, 8'h00, 1'b0, 0, 8'h00, 1'b0);
  endtask

  task automatic end_frame(input logic fd);
    cyc(1'b1, 1'b0, 8'h00, 1'b0, 0, 8'h00, fd);
    cyc(1'b1, 1'b0, 8'h00, 1'b0, 0, 8'h00, 1'b0);
  endtask

  initial begin
    // Reset with random bus activity, then a line before any VSYNC cycle.
    reset = 1'b1;
    for (int k = 0; k < 3; k++) begin
      cyc(1'($urandom), 1'($urandom), 8'($urandom), 1'b0, 0, 8'h00, 1'b0);
      check("reset_addr", WRITE_ADDR, 0);
      check("reset_data", WRITE_DATA, 8'h00);
    end
    reset = 1'b0;
    pixels(0, 4, 0, 1'b0);
    href_low();
    check("writes_before_vsync", writes, 0);

    // Two full lines of four pixels.
    writes = 0;
    start_frame();
    pixels(0, 4, 0, 1'b1);
    href_low();
    pixels(0, 4, 1, 1'b1);
    href_low();
    end_frame(1'b1);
    check("writes_basic_frame", writes, 8);

    // Oversized frame: 3 lines of 6 pixels cropped to 4x2.
    writes = 0;
    start_frame();
    for (int y = 0; y < 3; y++) begin
      pixels(0, 6, y, 1'b1);
      href_low();
    end
    end_frame(1'b1);
    check("writes_cropped_frame", writes, 8);

    // Odd byte count on line 0, then VSYNC rising mid-pixel on line 1.
    writes = 0;
    start_frame();
    cyc(1'b0, 1'b1, 8'hF8, 1'b0, 0, 8'h00, 1'b0);
    cyc(1'b0, 1'b1, 8'h00, 1'b1, 0, exp_data(0, 0), 1'b0);
    cyc(1'b0, 1'b1, 8'h07, 1'b0, 0, 8'h00, 1'b0);
    href_low();
    pixels(0, 2, 1, 1'b1);
    cyc(1'b0, 1'b1, hi_t[2], 1'b0, 0, 8'h00, 1'b0);
    cyc(1'b1, 1'b1, lo_t[2], 1'b0, 0, 8'h00, 1'b1);
    cyc(1'b1, 1'b0, 8'h00, 1'b0, 0, 8'h00, 1'b0);
    start_frame();
    pixels(0, 1, 0, 1'b1);
    href_low();
    end_frame(1'b1);
    check("writes_odd_bytes", writes, 4);

    // Reset after three pixels; the rest of the frame must be ignored.
    writes = 0;
    start_frame();
    pixels(0, 3, 0, 1'b1);
    reset = 1'b1;
    cyc(1'b0, 1'b1, hi_t[3], 1'b0, 0, 8'h00, 1'b0);
    check("midframe_reset_addr", WRITE_ADDR, 0);
    check("midframe_reset_data", WRITE_DATA, 8'h00);
    reset = 1'b0;
    cyc(1'b0, 1'b1, lo_t[3], 1'b0, 0, 8'h00, 1'b0);
    href_low();
    pixels(0, 4, 1, 1'b0);
    href_low();
    start_frame();
    pixels(0, 4, 0, 1'b1);
    href_low();
    end_frame(1'b1);
    check("writes_after_reset", writes, 7);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
